seven_segments_scan: RTL
========================

Name: seven_segments_scan

Overview:
Parametrised multi-digit, time-multiplexed seven-segment display driver. Latches a packed vector of DIGITS nibbles into a shadow register and scans the digits at a programmable refresh rate, driving one shared segment bus and a one-hot digit select. Adds several features over the single-digit combinational decoder:
- decimal or hex glyph mode
- leading-zero blanking
- anti-ghosting dead time
- output polarity options
- an invalid-digit flag

Sits between the counter datapath and the board display pins.

Parameters:
DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 1000, clock cycles per digit slot (>= 2)
DEADTIME, 1, cycles at start of each slot with all outputs off (0 <= DEADTIME < REFRESH_DIV)
HEX_MODE, 0, 0 = decimal glyphs with E for nibbles >9; 1 = hex glyphs 0-F
SEG_ACTIVE_LOW, 0, 1 inverts segments output
DIG_ACTIVE_LOW, 0, 1 inverts digit_sel output

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  synchronous active-low reset
value  input  4*DIGITS  packed nibbles; digit i = value[4i+3:4i]; digit 0 is rightmost / least significant
load  input  1  latch value into shadow register
blank_lz  input  1  suppress leading zeros
enable  input  1  0 forces all outputs inactive; scan keeps running
segments  output  7  segment drive; bit0 top, bit1 upper-right, bit2 lower-right, bit3 bottom, bit4 lower-left, bit5 upper-left, bit6 middle
digit_sel  output  DIGITS  one-hot digit enable
error  output  1  decimal mode with any shadow nibble >9

Behaviour:
- Reset (reset_n=0 at clock edge) has priority over every other input. It clears:
  - shadow to 0
  - tick to 0
  - idx to 0
  - error to 0
  - segments and digit_sel to the inactive level (all-zero logical, polarity applied)
- Shadow register: on load=1, shadow <= value at that edge. The new data is used for output from the following edge onward.
- Scan counters:
  - tick counts 0..REFRESH_DIV-1.
  - At tick==REFRESH_DIV-1: tick <= 0 and idx <= (idx==DIGITS-1) ? 0 : idx+1.
  - Counters run regardless of enable and load.
- Outputs are registered and computed from the current tick, idx and shadow:
  - If enable=0, tick<DEADTIME, or digit idx is blanked: segments=off, digit_sel=off.
  - Otherwise: digit_sel=one-hot(idx), segments=glyph(shadow nibble idx).
  - Polarity inversion is applied after this selection.
  - Latency is 1 cycle from tick/idx/shadow to pins.
- Decimal glyphs (bit6..bit0):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - 10-15 = E = 1111001
- Hex glyphs: same 0-9, plus A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001.
- Leading-zero blanking: digit i (i>=1) is blanked when blank_lz=1 and shadow nibbles DIGITS-1 down to i are all zero. Digit 0 is never blanked.
- error is registered: error <= (HEX_MODE==0) && (any shadow nibble >9). It reflects the shadow contents one cycle later and is independent of enable.
- Simultaneous load with slot change: the current edge updates the counters; the outputs computed at that edge use the old shadow.
- Reset mid-scan: the next slot after release is digit 0, tick 0. The first lit cycle occurs DEADTIME+1 edges after release.

Test Plan:
1. Bench setup for all scenarios: DIGITS=4, REFRESH_DIV=4, DEADTIME=1, HEX_MODE=0, polarities 0.
2. Reset/first scan: release reset with enable=1, load value=16'h1234 on the first cycle. Required response:
   - digit_sel 0001 with segments 1100110 (4) in slot 0, lit for 3 cycles and off for 1
   - then 0010 with 1001111, 0100 with 1011011, 1000 with 0000110
   - idx wraps to 0001 after 16 cycles
   - error stays 0
3. Leading-zero blanking: value=16'h0203, blank_lz=1. Required response:
   - digit 3 slot fully off
   - digit 2 shows 1011011
   - digit 1 shows 0111111 (not blanked)
   - digit 0 shows 1001111
   - with value=0, only digit 0 lights (0111111)
4. Error/decimal: value=16'h00A5. Required response:
   - digit 1 shows 1111001 and digit 0 shows 1101101
   - error=1 one cycle after load
   - reload 16'h0005 clears error on the following cycle
5. Hex mode (HEX_MODE=1, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1): value=16'hAbCd-equivalent 16'hABCD. Required response:
   - digit 0 pins = ~1011110 = 0100001, digit_sel = 1110
   - error stays 0
   - reset drives segments 1111111 and digit_sel 1111
6. Enable/reset mid-operation:
   - Deassert enable for 6 cycles: outputs go inactive on the next edge while idx keeps advancing; on re-enable, the lit digit matches free-running idx.
   - Assert reset_n=0 for 1 cycle mid-slot 2: the next lit digit is 0001 after DEADTIME+1 edges, and the shadow reads 0.

Source files
------------

// File: rtl/seven_segments_scan.sv
// seven_segments_scan: time-multiplexed multi-digit seven-segment driver.
// Holds a shadow copy of the digit nibbles and scans them one slot at a
// time. Each slot opens with a dead time to suppress ghosting. Supports
// optional leading-zero blanking, hex or decimal glyphs, and pin polarity.
module seven_segments_scan #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int DEADTIME       = 1,
    parameter int HEX_MODE       = 0,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int DIG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  enable,
    output logic [6:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  error
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // The inversion masks double as the reset value, so reset always
    // leaves the pins at their inactive level.
    localparam logic [6:0]        SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] DIG_INV = (DIG_ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                error_q, error_d;
    logic [6:0]          segments_q, segments_d;
    logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;

    logic [DIGITS-1:0]   lz;        // lz[i]: nibbles DIGITS-1..i are all zero
    logic                any_bad;   // some shadow nibble is above 9
    logic [3:0]          nib;
    logic                in_dead;
    logic                blanked;
    logic                lit;

    // Maps a nibble to its glyph (bit6 = middle ... bit0 = top).
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'd0:  g = 7'b0111111;
            4'd1:  g = 7'b0000110;
            4'd2:  g = 7'b1011011;
            4'd3:  g = 7'b1001111;
            4'd4:  g = 7'b1100110;
            4'd5:  g = 7'b1101101;
            4'd6:  g = 7'b1111101;
            4'd7:  g = 7'b0000111;
            4'd8:  g = 7'b1111111;
            4'd9:  g = 7'b1101111;
            4'd10: g = (HEX_MODE != 0) ? 7'b1110111 : 7'b1111001;
            4'd11: g = (HEX_MODE != 0) ? 7'b1111100 : 7'b1111001;
            4'd12: g = (HEX_MODE != 0) ? 7'b0111001 : 7'b1111001;
            4'd13: g = (HEX_MODE != 0) ? 7'b1011110 : 7'b1111001;
            4'd14: g = 7'b1111001;
            default: g = (HEX_MODE != 0) ? 7'b1110001 : 7'b1111001;
        endcase
        return g;
    endfunction

    // Leading-zero map and decimal range check over the shadow nibbles.
    always_comb begin
        logic allz;
        allz    = 1'b1;
        any_bad = 1'b0;
        lz      = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allz  = allz && (shadow_q[4*i +: 4] == 4'd0);
            lz[i] = allz;
            if (shadow_q[4*i +: 4] > 4'd9)
                any_bad = 1'b1;
        end
    end

    // Scan counters, shadow load and the next registered pin values.
    always_comb begin
        shadow_d = load ? value : shadow_q;

        tick_d = tick_q + 1'b1;
        idx_d  = idx_q;
        if (tick_q == TICK_W'(REFRESH_DIV - 1)) begin
            tick_d = '0;
            idx_d  = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // The output path reads the pre-load shadow; new data takes effect
        // one edge after the load.
        nib     = shadow_q[4*idx_q +: 4];
        in_dead = 32'(tick_q) < 32'(DEADTIME);
        blanked = blank_lz && (idx_q != '0) && lz[idx_q];
        lit     = enable && !in_dead && !blanked;

        segments_d  = (lit ? glyph(nib) : 7'd0) ^ SEG_INV;
        digit_sel_d = (lit ? (DIGITS'(1) << idx_q) : '0) ^ DIG_INV;
        error_d     = (HEX_MODE == 0) && any_bad;
    end

    // State register; reset wins over load, enable and the scan.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shadow_q    <= '0;
            tick_q      <= '0;
            idx_q       <= '0;
            error_q     <= 1'b0;
            segments_q  <= SEG_INV;
            digit_sel_q <= DIG_INV;
        end else begin
            shadow_q    <= shadow_d;
            tick_q      <= tick_d;
            idx_q       <= idx_d;
            error_q     <= error_d;
            segments_q  <= segments_d;
            digit_sel_q <= digit_sel_d;
        end
    end

    assign segments  = segments_q;
    assign digit_sel = digit_sel_q;
    assign error     = error_q;

endmodule
